// File: rtl/axis_fifo_pkg.sv
// Shared definitions for the single-clock AXI4-Stream packet FIFO:
// buffering-mode constants and helpers that derive beat widths from tdata width.
package axis_fifo_pkg;

  typedef enum int {
    CUT_THROUGH = 0,
    STORE_FWD   = 1
  } pkt_mode_e;

  localparam int BYTE_WDTH = 8;

  function automatic bit is_legal_data_wdth(input int wdth);
    return (wdth == 8) || (wdth == 16) || (wdth == 32) || (wdth == 64);
  endfunction

  function automatic int keep_wdth(input int data_wdth);
    return data_wdth / BYTE_WDTH;
  endfunction

  // One stored entry is {tlast, tkeep, tdata}.
  function automatic int beat_wdth(input int data_wdth);
    return 1 + keep_wdth(data_wdth) + data_wdth;
  endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Register-array storage for the stream FIFO: synchronous write and
// asynchronous read, so the head entry is available without a read cycle.
module axis_fifo_mem #(
  parameter int ADDR_WDTH = 4,
  parameter int WDTH      = 10
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_WDTH-1:0] wr_addr,
  input  logic [WDTH-1:0]      wr_data,
  input  logic [ADDR_WDTH-1:0] rd_addr,
  output logic [WDTH-1:0]      rd_data
);

  localparam int DEPTH = 2 ** ADDR_WDTH;

  logic [WDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; the pointers alone decide which entries are
  // live, so contents never need a defined value.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Single-clock AXI4-Stream FIFO with TLAST/TKEEP transport, optional
// store-and-forward packet mode, fill level, almost flags and synchronous flush.
module axis_pkt_fifo
  import axis_fifo_pkg::*;
#(
  parameter int ADDR_WDTH     = 4,
  parameter int DATA_WDTH     = 8,
  parameter int PKT_MODE      = 0,
  parameter int AFULL_THRESH  = 2 ** ADDR_WDTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                   axis_clk,
  input  logic                   axis_aresetn,
  input  logic                   flush,
  input  logic [DATA_WDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WDTH/8-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [DATA_WDTH-1:0]   m_axis_tdata,
  output logic [DATA_WDTH/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [ADDR_WDTH:0]     level,
  output logic [ADDR_WDTH:0]     pkt_cnt,
  output logic                   almost_full,
  output logic                   almost_empty
);

  localparam int KEEP_WDTH = keep_wdth(DATA_WDTH);
  localparam int LVL_WDTH  = ADDR_WDTH + 1;
  localparam bit CUT_THRU  = (PKT_MODE == int'(CUT_THROUGH));

  localparam logic [LVL_WDTH-1:0] AFULL_LVL  = LVL_WDTH'(AFULL_THRESH);
  localparam logic [LVL_WDTH-1:0] AEMPTY_LVL = LVL_WDTH'(AEMPTY_THRESH);
  localparam logic [LVL_WDTH-1:0] LVL_ONE    = LVL_WDTH'(1);

  if (!is_legal_data_wdth(DATA_WDTH)) begin : g_bad_data_wdth
    $fatal(1, "axis_pkt_fifo: DATA_WDTH must be 8, 16, 32 or 64");
  end

  typedef struct packed {
    logic                 tlast;
    logic [KEEP_WDTH-1:0] tkeep;
    logic [DATA_WDTH-1:0] tdata;
  } beat_t;

  logic [LVL_WDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_WDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_WDTH-1:0] level_q, level_d;
  logic [LVL_WDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic                almost_full_q, almost_full_d;
  logic                almost_empty_q, almost_empty_d;
  logic                s_ready_en_q, s_ready_en_d;

  logic  empty, full, wr_en, rd_en, pkt_in, pkt_out;
  beat_t wr_beat, rd_beat;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_WDTH] != rd_ptr_q[ADDR_WDTH]) &&
                 (wr_ptr_q[ADDR_WDTH-1:0] == rd_ptr_q[ADDR_WDTH-1:0]);

  // Input side stays closed until the first edge after reset release.
  assign s_axis_tready = s_ready_en_q & ~full & ~flush;
  // A full FIFO releases its head even without a complete packet, so an
  // oversized packet cannot deadlock the store-and-forward mode.
  assign m_axis_tvalid = ~empty & (CUT_THRU | (pkt_cnt_q != '0) | full);

  assign wr_en   = s_axis_tvalid & s_axis_tready;
  assign rd_en   = m_axis_tvalid & m_axis_tready;
  assign pkt_in  = wr_en & s_axis_tlast;
  // Gated so a force-released packet whose tlast leaves early cannot underflow.
  assign pkt_out = rd_en & rd_beat.tlast & (pkt_cnt_q != '0);

  assign wr_beat = '{tlast: s_axis_tlast, tkeep: s_axis_tkeep, tdata: s_axis_tdata};

  axis_fifo_mem #(
    .ADDR_WDTH (ADDR_WDTH),
    .WDTH      ($bits(beat_t))
  ) u_mem (
    .clk     (axis_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q[ADDR_WDTH-1:0]),
    .wr_data (wr_beat),
    .rd_addr (rd_ptr_q[ADDR_WDTH-1:0]),
    .rd_data (rd_beat)
  );

  // NOTE: every variable gets a default before any branch, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d     = wr_ptr_q + LVL_WDTH'(wr_en);
    rd_ptr_d     = rd_ptr_q + LVL_WDTH'(rd_en);
    level_d      = level_q;
    pkt_cnt_d    = pkt_cnt_q;
    s_ready_en_d = 1'b1;

    if (wr_en && !rd_en) begin
      level_d = level_q + LVL_ONE;
    end else if (!wr_en && rd_en) begin
      level_d = level_q - LVL_ONE;
    end

    if (pkt_in && !pkt_out) begin
      pkt_cnt_d = pkt_cnt_q + LVL_ONE;
    end else if (!pkt_in && pkt_out) begin
      pkt_cnt_d = pkt_cnt_q - LVL_ONE;
    end

    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      pkt_cnt_d = '0;
    end

    almost_full_d  = (level_d >= AFULL_LVL);
    almost_empty_d = (level_d <= AEMPTY_LVL);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge axis_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      pkt_cnt_q      <= '0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      s_ready_en_q   <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      pkt_cnt_q      <= pkt_cnt_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      s_ready_en_q   <= s_ready_en_d;
    end
  end

  assign m_axis_tdata = rd_beat.tdata;
  assign m_axis_tkeep = rd_beat.tkeep;
  assign m_axis_tlast = rd_beat.tlast;
  assign level        = level_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo: one cut-through and one store-and-forward
// instance share the stimulus; each sequence checks the instance it targets.
module tb_axis_pkt_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [7:0] s_tdata;
  logic [0:0] s_tkeep;
  logic       s_tlast, s_tvalid, m_tready;

  logic       ct_s_tready, ct_m_tvalid, ct_m_tlast, ct_af, ct_ae;
  logic [7:0] ct_m_tdata;
  logic [0:0] ct_m_tkeep;
  logic [4:0] ct_level, ct_pkt_cnt;

  logic       sf_s_tready, sf_m_tvalid, sf_m_tlast, sf_af, sf_ae;
  logic [7:0] sf_m_tdata;
  logic [0:0] sf_m_tkeep;
  logic [4:0] sf_level, sf_pkt_cnt;

  always #5 clk = ~clk;

  axis_pkt_fifo #(.ADDR_WDTH(4), .DATA_WDTH(8), .PKT_MODE(0)) dut_ct (
    .axis_clk(clk), .axis_aresetn(rst_n), .flush(flush),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(ct_s_tready),
    .m_axis_tdata(ct_m_tdata), .m_axis_tkeep(ct_m_tkeep), .m_axis_tlast(ct_m_tlast),
    .m_axis_tvalid(ct_m_tvalid), .m_axis_tready(m_tready),
    .level(ct_level), .pkt_cnt(ct_pkt_cnt), .almost_full(ct_af), .almost_empty(ct_ae)
  );

  axis_pkt_fifo #(.ADDR_WDTH(4), .DATA_WDTH(8), .PKT_MODE(1)) dut_sf (
    .axis_clk(clk), .axis_aresetn(rst_n), .flush(flush),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(sf_s_tready),
    .m_axis_tdata(sf_m_tdata), .m_axis_tkeep(sf_m_tkeep), .m_axis_tlast(sf_m_tlast),
    .m_axis_tvalid(sf_m_tvalid), .m_axis_tready(m_tready),
    .level(sf_level), .pkt_cnt(sf_pkt_cnt), .almost_full(sf_af), .almost_empty(sf_ae)
  );

  typedef struct {
    logic       s_vld;
    logic [7:0] s_data;
    logic       m_rdy;
    logic       exp_m_vld;
    logic [7:0] exp_m_data;
    logic [4:0] exp_level;
    logic       exp_af;
    logic       exp_ae;
    logic       exp_s_rdy;
  } vec_t;

  vec_t       vecs [32];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         wr_idx, rd_idx, n_sent, n_rcv, exp_pkts;
  logic       wr_hs, rd_hs;
  logic [8:0] exp_beat;
  logic [8:0] sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    s_tkeep  = 1'b1;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
  endtask

  task automatic do_flush();
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{s_vld: 1'b1, s_data: 8'hA0 + 8'(i), m_rdy: 1'b0,
                  exp_m_vld: (i != 0), exp_m_data: 8'hA0, exp_level: 5'(i + 1),
                  exp_af: (i + 1 >= 14), exp_ae: (i + 1 <= 2), exp_s_rdy: (i + 1 < 16)};
      vecs[16 + i] = '{s_vld: 1'b0, s_data: 8'h00, m_rdy: 1'b1,
                       exp_m_vld: 1'b1, exp_m_data: 8'hA0 + 8'(i), exp_level: 5'(15 - i),
                       exp_af: (15 - i >= 14), exp_ae: (15 - i <= 2), exp_s_rdy: 1'b1};
    end

    // Reset values and tready release on the first edge after reset.
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_tready", ct_s_tready, 0);
    check("rst_m_tvalid", ct_m_tvalid, 0);
    check("rst_level", ct_level, 0);
    check("rst_pkt_cnt", ct_pkt_cnt, 0);
    check("rst_almost_full", ct_af, 0);
    check("rst_almost_empty", ct_ae, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_tready_before_edge", ct_s_tready, 0);
    tick();
    check("rst_tready_after_edge", ct_s_tready, 1);
    check("rst_sf_tready_after_edge", sf_s_tready, 1);

    // Test 1: fill the cut-through FIFO to full, then drain it.
    for (int v = 0; v < 32; v++) begin
      s_tvalid = vecs[v].s_vld;
      s_tdata  = vecs[v].s_data;
      s_tlast  = 1'b0;
      m_tready = vecs[v].m_rdy;
      #1;
      check($sformatf("t1_m_tvalid[%0d]", v), ct_m_tvalid, vecs[v].exp_m_vld);
      if (vecs[v].exp_m_vld) check($sformatf("t1_m_tdata[%0d]", v), ct_m_tdata, vecs[v].exp_m_data);
      tick();
      check($sformatf("t1_level[%0d]", v), ct_level, vecs[v].exp_level);
      check($sformatf("t1_almost_full[%0d]", v), ct_af, vecs[v].exp_af);
      check($sformatf("t1_almost_empty[%0d]", v), ct_ae, vecs[v].exp_ae);
      check($sformatf("t1_s_tready[%0d]", v), ct_s_tready, vecs[v].exp_s_rdy);
    end

    // Test 2: store-and-forward holds a 3-beat packet until its tlast is stored.
    do_flush();
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'h11 * 8'(i + 1);
      s_tkeep  = (i != 1);
      s_tlast  = (i == 2);
      #1;
      check($sformatf("t2_s_tready[%0d]", i), sf_s_tready, 1);
      tick();
      check($sformatf("t2_m_tvalid[%0d]", i), sf_m_tvalid, (i == 2));
      check($sformatf("t2_pkt_cnt[%0d]", i), sf_pkt_cnt, (i == 2));
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tkeep  = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t2_rd_tvalid[%0d]", i), sf_m_tvalid, 1);
      check($sformatf("t2_rd_tdata[%0d]", i), sf_m_tdata, 8'h11 * 8'(i + 1));
      check($sformatf("t2_rd_tkeep[%0d]", i), sf_m_tkeep, (i != 1));
      check($sformatf("t2_rd_tlast[%0d]", i), sf_m_tlast, (i == 2));
      tick();
      check($sformatf("t2_rd_pkt_cnt[%0d]", i), sf_pkt_cnt, (i != 2));
    end
    check("t2_end_tvalid", sf_m_tvalid, 0);
    check("t2_end_level", sf_level, 0);

    // Test 3: a 20-beat packet overflows store-and-forward and is force-released.
    do_flush();
    for (int i = 0; i < 16; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'h40 + 8'(i);
      s_tlast  = 1'b0;
      tick();
    end
    s_tvalid = 1'b0;
    #1;
    check("t3_full_level", sf_level, 16);
    check("t3_escape_tvalid", sf_m_tvalid, 1);
    check("t3_full_pkt_cnt", sf_pkt_cnt, 0);
    check("t3_full_s_tready", sf_s_tready, 0);
    wr_idx = 16;
    rd_idx = 0;
    for (int cyc = 0; cyc < 200 && rd_idx < 20; cyc++) begin
      s_tvalid = (wr_idx < 20);
      s_tdata  = 8'h40 + 8'(wr_idx);
      s_tlast  = (wr_idx == 19);
      m_tready = 1'b1;
      #1;
      wr_hs = s_tvalid & sf_s_tready;
      rd_hs = sf_m_tvalid;
      if (rd_hs) begin
        check($sformatf("t3_tdata[%0d]", rd_idx), sf_m_tdata, 8'h40 + 8'(rd_idx));
        check($sformatf("t3_tlast[%0d]", rd_idx), sf_m_tlast, (rd_idx == 19));
      end
      tick();
      check("t3_pkt_cnt_range", (sf_pkt_cnt <= 5'd1), 1);
      if (wr_hs) wr_idx++;
      if (rd_hs) rd_idx++;
    end
    check("t3_beats_delivered", rd_idx, 20);
    check("t3_end_level", sf_level, 0);
    check("t3_end_pkt_cnt", sf_pkt_cnt, 0);

    // Test 4: simultaneous read/write at level 5, then 100 beats across pointer wrap.
    do_flush();
    for (int i = 0; i < 5; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'h50 + 8'(i);
      s_tlast  = (i == 0) || (i == 4);
      tick();
    end
    s_tvalid = 1'b0;
    #1;
    check("t4_pre_level", ct_level, 5);
    check("t4_pre_pkt_cnt", ct_pkt_cnt, 2);
    s_tvalid = 1'b1;
    s_tdata  = 8'h55;
    s_tlast  = 1'b1;
    m_tready = 1'b1;
    #1;
    check("t4_sim_s_tready", ct_s_tready, 1);
    check("t4_sim_head", {ct_m_tvalid, ct_m_tlast, ct_m_tdata}, {2'b11, 8'h50});
    tick();
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    #1;
    check("t4_sim_level", ct_level, 5);
    check("t4_sim_pkt_cnt", ct_pkt_cnt, 2);
    sb = {9'h051, 9'h052, 9'h053, 9'h154, 9'h155};
    n_sent = 0;
    n_rcv  = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (n_sent >= 100 && sb.size() == 0) break;
      s_tvalid = (n_sent < 100);
      s_tdata  = 8'h56 + 8'(n_sent);
      s_tlast  = (s_tdata[2:0] == 3'd0);
      m_tready = 1'b1;
      #1;
      wr_hs = s_tvalid & ct_s_tready;
      rd_hs = ct_m_tvalid;
      if (rd_hs) begin
        exp_beat = 9'h1FF;
        if (sb.size() != 0) exp_beat = sb.pop_front();
        check($sformatf("t4_stream_beat[%0d]", n_rcv), {ct_m_tlast, ct_m_tdata}, exp_beat);
        n_rcv++;
      end
      if (wr_hs) begin
        sb.push_back({s_tlast, s_tdata});
        n_sent++;
      end
      tick();
      exp_pkts = 0;
      foreach (sb[k]) if (sb[k][8]) exp_pkts++;
      check("t4_stream_level", ct_level, sb.size());
      check("t4_stream_pkt_cnt", ct_pkt_cnt, exp_pkts);
    end
    check("t4_beats_received", n_rcv, 105);
    check("t4_end_level", ct_level, 0);
    check("t4_end_pkt_cnt", ct_pkt_cnt, 0);

    // Test 5: flush at level 7 mid-packet, then a clean packet passes.
    do_flush();
    for (int i = 0; i < 7; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'h70 + 8'(i);
      s_tlast  = (i == 2);
      tick();
    end
    s_tvalid = 1'b0;
    #1;
    check("t5_pre_level", ct_level, 7);
    check("t5_pre_pkt_cnt", ct_pkt_cnt, 1);
    flush    = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 8'h77;
    s_tlast  = 1'b0;
    #1;
    check("t5_tready_in_flush", ct_s_tready, 0);
    tick();
    flush    = 1'b0;
    s_tvalid = 1'b0;
    #1;
    check("t5_post_level", ct_level, 0);
    check("t5_post_pkt_cnt", ct_pkt_cnt, 0);
    check("t5_post_m_tvalid", ct_m_tvalid, 0);
    check("t5_post_s_tready", ct_s_tready, 1);
    check("t5_post_almost_empty", ct_ae, 1);
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'hC0 + 8'(i);
      s_tlast  = (i == 2);
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    #1;
    check("t5_pkt_level", ct_level, 3);
    check("t5_pkt_pkt_cnt", ct_pkt_cnt, 1);
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t5_rd_beat[%0d]", i), {ct_m_tvalid, ct_m_tlast, ct_m_tdata},
            {1'b1, (i == 2), 8'hC0 + 8'(i)});
      tick();
    end
    check("t5_end_level", ct_level, 0);

    // Test 6: asynchronous reset in the middle of a transfer.
    do_flush();
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'hE0 + 8'(i);
      s_tlast  = 1'b0;
      tick();
    end
    s_tdata  = 8'hE3;
    m_tready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_s_tready", ct_s_tready, 0);
    check("t6_rst_m_tvalid", ct_m_tvalid, 0);
    check("t6_rst_level", ct_level, 0);
    check("t6_rst_pkt_cnt", ct_pkt_cnt, 0);
    check("t6_rst_almost_full", ct_af, 0);
    check("t6_rst_almost_empty", ct_ae, 1);
    check("t6_rst_sf_m_tvalid", sf_m_tvalid, 0);
    tick();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_tready_before_edge", ct_s_tready, 0);
    tick();
    check("t6_tready_after_edge", ct_s_tready, 1);
    check("t6_m_tvalid_after_edge", ct_m_tvalid, 0);
    check("t6_level_after_edge", ct_level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_pkt_fifo.md
Name: axis_pkt_fifo

Overview:
- Single-clock AXI4-Stream FIFO. Parametrised successor of the dual-clock stream FIFO.
- Adds TLAST/TKEEP transport, a store-and-forward packet mode, a fill-level output, almost-full/almost-empty flags and a synchronous flush.
- Sits between stream producers and consumers that share one clock domain, e.g. ahead of packet parsers that must not see partial frames.

Parameters:
- ADDR_WDTH, 4: log2 of depth. DEPTH = 2**ADDR_WDTH entries.
- DATA_WDTH, 8: tdata width; legal values 8/16/32/64, otherwise $fatal at elaboration.
- PKT_MODE, 0: 0 = cut-through; 1 = store-and-forward (output held until a full packet is stored).
- AFULL_THRESH, 2**ADDR_WDTH-2: almost_full asserted when level >= this value.
- AEMPTY_THRESH, 2: almost_empty asserted when level <= this value.

Ports:
- axis_clk  in  1  the single clock.
- axis_aresetn  in  1  reset, asynchronous active-low.
- flush  in  1  synchronous clear, active-high.
- s_axis_tdata  in  DATA_WDTH  input data.
- s_axis_tkeep  in  DATA_WDTH/8  input byte enables.
- s_axis_tlast  in  1  input end of packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  DATA_WDTH  output data.
- m_axis_tkeep  out  DATA_WDTH/8  output byte enables.
- m_axis_tlast  out  1  output end of packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- level  out  ADDR_WDTH+1  number of stored beats, 0..DEPTH.
- pkt_cnt  out  ADDR_WDTH+1  number of complete packets stored.
- almost_full  out  1  level >= AFULL_THRESH.
- almost_empty  out  1  level <= AEMPTY_THRESH.

Behaviour:
- Reset: axis_aresetn low clears wr_ptr, rd_ptr, level, pkt_cnt. Outputs in reset: s_axis_tready=0, m_axis_tvalid=0, level=0, pkt_cnt=0, almost_full=0, almost_empty=1. s_axis_tready rises on the first clock edge after reset release.
- Storage: DEPTH x {tlast, tkeep, tdata}, written synchronously, read asynchronously at rd_ptr (first-word fall-through).
- Pointers: ADDR_WDTH+1 bits each, wrapping naturally. empty = (wr_ptr == rd_ptr). full = MSBs differ and lower bits are equal.
- Write beat: s_axis_tvalid & s_axis_tready, where s_axis_tready = ~full & ~flush.
  - Full with a simultaneous read: tready stays 0; no same-cycle pass-through.
- Read beat: m_axis_tvalid & m_axis_tready.
- m_axis_tvalid:
  - PKT_MODE=0: ~empty.
  - PKT_MODE=1: ~empty & (pkt_cnt != 0 | full). The full term is a deadlock escape: a packet longer than DEPTH is released cut-through.
- Latency: a beat written at edge N is visible on m_axis_* after edge N (one cycle) in PKT_MODE=0. In PKT_MODE=1 it is visible after the edge that writes its tlast beat.
- level: +1 on write only, -1 on read only, unchanged on simultaneous read and write. Registered.
- pkt_cnt: +1 on a write beat with tlast, -1 on a read beat with tlast, unchanged when both occur in the same cycle. Saturates logically at DEPTH; cannot exceed level.
- Escape case: if a forced-release partial packet's tlast is read before it is written, pkt_cnt must not underflow. The decrement is gated with pkt_cnt != 0.
- almost_full / almost_empty: registered, computed from next-state level, so they align with level.
- flush: at the edge where flush=1, pointers, level and pkt_cnt are cleared.
  - The beat in flight is dropped, even if it is mid-packet.
  - A read that handshakes in the flush cycle is still valid to the consumer. Its data is then discarded from the FIFO.
- Wrap-around: pointer LSBs roll DEPTH-1 -> 0 with the MSB toggling. No special handling.
- m_axis_* data while m_axis_tvalid=0: don't-care. The bench must not check it.

Decomposition:
- Package axis_fifo_pkg:
  - typedef for the beat struct {tlast, tkeep, tdata}, parametrised via localparam widths.
  - Legal DATA_WDTH check function.
  - PKT_MODE enum constants CUT_THROUGH and STORE_FWD.
- Sub-module axis_fifo_mem: single-clock register array, synchronous write, asynchronous read, no reset on contents.
- Control logic (pointers, counters, flags) lives in axis_pkt_fifo.

Test Plan:
1. PKT_MODE=0, ADDR_WDTH=4: write 16 beats with m_axis_tready=0 -> s_axis_tready=0 after the 16th beat, level=16, almost_full=1 from level 14. Then read all -> data in order, level=0, almost_empty=1.
2. PKT_MODE=1: write 3 beats with tlast on beat 3 -> m_axis_tvalid=0 until the edge after beat 3, then pkt_cnt=1. Read 3 beats -> tlast on the 3rd, pkt_cnt=0.
3. PKT_MODE=1, DEPTH=16: send a 20-beat packet -> at level=16 m_axis_tvalid=1 (escape). All 20 beats are delivered in order, pkt_cnt is never negative and ends at 0.
4. Simultaneous read and write at level=5 with tlast on both beats -> level stays 5, pkt_cnt is unchanged. Run continuous streaming for 100 beats across pointer wrap -> no loss or duplication.
5. Flush at level=7, mid-packet -> next cycle level=0, pkt_cnt=0, m_axis_tvalid=0, s_axis_tready=1. A subsequent packet passes intact.
6. Assert axis_aresetn asynchronously mid-transfer -> outputs take their reset values immediately. s_axis_tready=0 until the first edge after release.
